// File: rtl/reg_bank_scoreboard.sv
// Register bank with decoded destination load, two combinational read ports,
// optional write-to-read bypass and a per-register busy scoreboard.
module reg_bank_scoreboard #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    parameter int SEL_WIDTH  = $clog2(NUM_REGS),
    parameter int BYPASS     = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [SEL_WIDTH-1:0]  DST_SELECTION,
    input  logic                  LOAD_DST,
    input  logic [DATA_WIDTH-1:0] DST_DATA,
    input  logic                  RESERVE,
    input  logic [SEL_WIDTH-1:0]  RESERVE_SEL,
    input  logic [SEL_WIDTH-1:0]  SRC_A_SELECTION,
    input  logic [SEL_WIDTH-1:0]  SRC_B_SELECTION,
    output logic [DATA_WIDTH-1:0] SRC_A_DATA,
    output logic [DATA_WIDTH-1:0] SRC_B_DATA,
    output logic                  SRC_A_BUSY,
    output logic                  SRC_B_BUSY,
    output logic                  RESERVE_STALL,
    output logic [NUM_REGS-1:0]   LOAD_STROBES,
    output logic [NUM_REGS-1:0]   BUSY_MASK
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;

    // Returns {busy, data}; out-of-range indices match no register and read as zero.
    function automatic logic [DATA_WIDTH:0] read_port(input logic [SEL_WIDTH-1:0] sel);
        logic [DATA_WIDTH:0] r;
        r = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(sel) == i) r = {busy_q[i], regs_q[i]};
        end
        if (BYPASS != 0 && LOAD_DST && sel == DST_SELECTION && int'(DST_SELECTION) < NUM_REGS)
            r = {1'b0, DST_DATA};
        return r;
    endfunction

    always_comb begin
        LOAD_STROBES = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            LOAD_STROBES[i] = LOAD_DST && (int'(DST_SELECTION) == i);
        end
    end

    always_comb begin
        RESERVE_STALL = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(RESERVE_SEL) == i) RESERVE_STALL = RESERVE && busy_q[i];
        end
    end

    // Write clears busy first so an accepted reservation on the same edge wins.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (LOAD_STROBES[i]) begin
                regs_d[i] = DST_DATA;
                busy_d[i] = 1'b0;
            end
            if (RESERVE && int'(RESERVE_SEL) == i && !busy_q[i]) busy_d[i] = 1'b1;
        end
    end

    always_comb begin
        {SRC_A_BUSY, SRC_A_DATA} = read_port(SRC_A_SELECTION);
        {SRC_B_BUSY, SRC_B_DATA} = read_port(SRC_B_SELECTION);
    end

    assign BUSY_MASK = busy_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

endmodule
